// File: rtl/mem_access_stage_pkg.sv
// Shared widths, enable levels and FSM encoding for the MEM pipeline stage.
package mem_access_stage_pkg;

    localparam int unsigned DATA_W      = 32;
    localparam int unsigned REG_ADDR_W  = 5;
    localparam int unsigned MEM_STATE_W = 1;

    localparam logic ENABLED  = 1'b1;
    localparam logic DISABLED = 1'b0;

    typedef enum logic [MEM_STATE_W-1:0] {
        MEM_ST_IDLE = 1'b0,
        MEM_ST_BUS  = 1'b1
    } mem_state_e;

endpackage

// File: rtl/mem_access_stage_if.sv
// Data-memory bus: req/ack handshake with word address, write data and read data.
interface mem_access_stage_if;
    import mem_access_stage_pkg::*;

    logic              dbus_req;
    logic              dbus_we;
    logic [DATA_W-1:0] dbus_addr;
    logic [DATA_W-1:0] dbus_wdata;
    logic [DATA_W-1:0] dbus_rdata;
    logic              dbus_ack;

    modport master (
        output dbus_req, dbus_we, dbus_addr, dbus_wdata,
        input  dbus_rdata, dbus_ack
    );

    modport slave (
        input  dbus_req, dbus_we, dbus_addr, dbus_wdata,
        output dbus_rdata, dbus_ack
    );

endinterface

// File: rtl/mem_access_stage.sv
// MEM stage: word loads/stores over the data bus, upstream stall while a request
// is outstanding, and registered MEM/WB outputs with misalign/timeout pulses.
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned CNT_W          = 5
) (
    input  logic                  clk,
    input  logic                  reset_,
    input  logic                  mem_to_reg_mem,
    input  logic                  mem_write_mem,
    input  logic                  reg_write_mem,
    input  logic [DATA_W-1:0]     alu_out_mem,
    input  logic [REG_ADDR_W-1:0] dst_addr_mem,
    input  logic [DATA_W-1:0]     dst_data_mem,
    mem_access_stage_if.master    dbus,
    output logic                  stall_mem,
    output logic                  reg_write_wb,
    output logic [REG_ADDR_W-1:0] dst_addr_wb,
    output logic [DATA_W-1:0]     wb_data_wb,
    output logic                  mem_misalign,
    output logic                  bus_err
);

    mem_state_e       state_q;
    mem_state_e       state_d;
    logic [CNT_W-1:0] cnt_q;

    logic access;
    logic aligned;
    logic timeout;

    assign access  = mem_to_reg_mem | mem_write_mem;
    assign aligned = (alu_out_mem[1:0] == 2'b00);
    assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset_) begin
            state_q <= MEM_ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            MEM_ST_IDLE: if (access && aligned)            state_d = MEM_ST_BUS;
            MEM_ST_BUS:  if (dbus.dbus_ack || timeout)     state_d = MEM_ST_IDLE;
            default:                                       state_d = MEM_ST_IDLE;
        endcase
    end

    // Ack takes priority over timeout, so the final BUS cycle never stalls.
    always_comb begin
        stall_mem = DISABLED;
        unique case (state_q)
            MEM_ST_IDLE: stall_mem = access && aligned;
            MEM_ST_BUS:  stall_mem = !dbus.dbus_ack && !timeout;
            default:     stall_mem = DISABLED;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset_) begin
            cnt_q           <= '0;
            dbus.dbus_req   <= DISABLED;
            dbus.dbus_we    <= DISABLED;
            dbus.dbus_addr  <= '0;
            dbus.dbus_wdata <= '0;
            reg_write_wb    <= DISABLED;
            dst_addr_wb     <= '0;
            wb_data_wb      <= '0;
            mem_misalign    <= DISABLED;
            bus_err         <= DISABLED;
        end else begin
            mem_misalign <= DISABLED;
            bus_err      <= DISABLED;
            unique case (state_q)
                MEM_ST_IDLE: begin
                    if (!access) begin
                        reg_write_wb <= reg_write_mem;
                        dst_addr_wb  <= dst_addr_mem;
                        wb_data_wb   <= alu_out_mem;
                    end else if (!aligned) begin
                        mem_misalign <= ENABLED;
                        reg_write_wb <= DISABLED;
                    end else begin
                        dbus.dbus_req   <= ENABLED;
                        dbus.dbus_we    <= mem_write_mem;
                        dbus.dbus_addr  <= alu_out_mem;
                        dbus.dbus_wdata <= dst_data_mem;
                        cnt_q           <= '0;
                        reg_write_wb    <= DISABLED;
                    end
                end
                MEM_ST_BUS: begin
                    // Latched dbus_we distinguishes store from load at completion.
                    if (dbus.dbus_ack) begin
                        dbus.dbus_req <= DISABLED;
                        if (dbus.dbus_we) begin
                            reg_write_wb <= DISABLED;
                        end else begin
                            reg_write_wb <= reg_write_mem;
                            dst_addr_wb  <= dst_addr_mem;
                            wb_data_wb   <= dbus.dbus_rdata;
                        end
                    end else if (timeout) begin
                        dbus.dbus_req <= DISABLED;
                        bus_err       <= ENABLED;
                        reg_write_wb  <= DISABLED;
                    end else begin
                        cnt_q        <= cnt_q + CNT_W'(1);
                        reg_write_wb <= DISABLED;
                    end
                end
                default: begin
                    dbus.dbus_req <= DISABLED;
                    reg_write_wb  <= DISABLED;
                end
            endcase
        end
    end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- MEM-stage consumer of the EX/MEM pipeline register outputs; drives the data-memory bus and produces registered MEM/WB inputs.
- Performs word loads/stores over a req/ack handshake and stalls upstream stages while a bus transaction is outstanding.
- Passes non-memory results through in one cycle and flags misaligned accesses and bus timeouts.

Parameters:
- TIMEOUT_CYCLES, 16, max BUS-state cycles without dbus_ack before abort (>=1)
- CNT_W, 5, timeout counter width; must satisfy 2^CNT_W > TIMEOUT_CYCLES

Ports:
- clk  in  1  system clock
- reset_  in  1  synchronous reset, active-high (one clock; polarity/synchronicity fixed)
- mem_to_reg_mem  in  1  load: writeback data from memory
- mem_write_mem  in  1  store request
- reg_write_mem  in  1  instruction writes a register
- alu_out_mem  in  `DataBus  address for ld/st; result for non-memory ops
- dst_addr_mem  in  `RegAddrBus  destination register
- dst_data_mem  in  `DataBus  store data
- dbus_req  out  1  bus request, held until ack/abort
- dbus_we  out  1  1=write
- dbus_addr  out  `DataBus  word address (bits[1:0]=0)
- dbus_wdata  out  `DataBus  store data
- dbus_rdata  in  `DataBus  read data, valid with dbus_ack
- dbus_ack  in  1  one-cycle completion strobe
- stall_mem  out  1  combinational; freezes PC/IF/ID/EX and EX/MEM register
- reg_write_wb  out  1  registered writeback enable
- dst_addr_wb  out  `RegAddrBus  registered destination
- wb_data_wb  out  `DataBus  registered writeback data
- mem_misalign  out  1  registered one-cycle error pulse
- bus_err  out  1  registered one-cycle timeout pulse

Behaviour:
- access = mem_to_reg_mem | mem_write_mem; is_store = mem_write_mem (store wins if both set; load ignored); aligned = alu_out_mem[1:0]==0.
- Reset (reset_==1 at posedge): state=IDLE, timeout counter=0; dbus_req/dbus_we=0, dbus_addr/dbus_wdata=0; reg_write_wb=0, dst_addr_wb=0, wb_data_wb=0, mem_misalign=0, bus_err=0. Reset mid-transaction drops dbus_req at that edge; late ack afterwards ignored.
- FSM states: IDLE, BUS.
- IDLE, !access: next edge reg_write_wb<=reg_write_mem, dst_addr_wb<=dst_addr_mem, wb_data_wb<=alu_out_mem; latency 1; stall_mem=0.
- IDLE, access & !aligned: no bus cycle; stall_mem=0; next edge mem_misalign<=1, reg_write_wb<=0; stays IDLE.
- IDLE, access & aligned: stall_mem=1; next edge -> BUS, dbus_req<=1, dbus_we<=is_store, dbus_addr<=alu_out_mem, dbus_wdata<=dst_data_mem, counter<=0; reg_write_wb<=0 (bubble).
- BUS: dbus_req/we/addr/wdata stable; stall_mem = !dbus_ack & !timeout, where timeout = (counter==TIMEOUT_CYCLES-1).
- BUS & dbus_ack: next edge -> IDLE, dbus_req<=0; load: reg_write_wb<=reg_write_mem, wb_data_wb<=dbus_rdata; store: reg_write_wb<=0. Minimum load/store latency 2 cycles (ack on first BUS cycle).
- BUS & !ack & !timeout: counter++, reg_write_wb<=0.
- BUS & !ack & timeout: stall_mem=0; next edge -> IDLE, dbus_req<=0, bus_err<=1, reg_write_wb<=0 (instruction retires with no writeback).
- ack and timeout in same cycle: ack wins, no bus_err.
- dbus_ack in IDLE: ignored.
- mem_misalign/bus_err high exactly one cycle; otherwise 0.
- Inputs from EX/MEM are assumed stable while stall_mem=1.

Decomposition:
- Shared defines: `DataBus, `RegAddrBus, `DATA_W, `REG_ADDR_W, `ENABLED/`DISABLED, plus new MEM_ST_IDLE/MEM_ST_BUS encodings and `MEM_STATE_W.
- No sub-module; the timeout counter stays inline.

Test Plan:
- Non-memory op: alu_out=0x0000_1234, dst=5, reg_write=1 -> next cycle reg_write_wb=1, dst_addr_wb=5, wb_data_wb=0x1234, stall_mem never high.
- Load addr 0x100, ack 3 cycles after req rises, rdata=0xDEAD_BEEF -> stall_mem high 4 cycles, dbus_we=0, dbus_addr=0x100; then reg_write_wb=1, wb_data_wb=0xDEADBEEF for one cycle.
- Store addr 0x204, data 0xCAFE_0001, ack on first BUS cycle -> dbus_we=1, dbus_wdata=0xCAFE0001, stall 1 cycle, reg_write_wb stays 0.
- Load addr 0x102 -> no dbus_req, mem_misalign pulse 1 cycle, reg_write_wb=0, no stall.
- Load with no ack, TIMEOUT_CYCLES=4 -> dbus_req high 4 cycles, bus_err pulse, reg_write_wb=0, back to IDLE; late ack then ignored.
- reset_=1 during BUS of a load -> dbus_req=0 next cycle, all outputs 0; subsequent ack produces no writeback.
